// File: rtl/rv32_pkg.sv
// Shared encodings for the rv32_core slice: opcode field values, ALU op codes,
// store size encoding and load/branch funct3 values.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RIDX = 5;

  // inst[6:2] major opcodes
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    MSZ_NONE = 2'b00,
    MSZ_BYTE = 2'b01,
    MSZ_HALF = 2'b10,
    MSZ_WORD = 2'b11
  } memsize_e;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Right-aligned load data extended according to the load funct3.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] d);
    case (f3)
      LD_LB:   return {{24{d[7]}}, d[7:0]};
      LD_LH:   return {{16{d[15]}}, d[15:0]};
      LD_LW:   return d;
      LD_LBU:  return {24'b0, d[7:0]};
      LD_LHU:  return {16'b0, d[15:0]};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// RV32I integer ALU: funct3-coded op, op2 selects SUB/SRA.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  alu_op_e         op,
  input  logic            op2,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [4:0] shamt;
  assign shamt = y[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = op2 ? (x - y) : (x + y);
      ALU_SLL:  result = x << shamt;
      ALU_SLT:  result = XLEN'($signed(x) < $signed(y));
      ALU_SLTU: result = XLEN'(x < y);
      ALU_XOR:  result = x ^ y;
      ALU_SRL:  result = op2 ? XLEN'($signed(x) >>> shamt) : (x >> shamt);
      ALU_OR:   result = x | y;
      ALU_AND:  result = x & y;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rv32_core.sv
// Single-cycle RV32I core: PC, inline decoder, 32x32 register file, ALU.
// Optional debug register-load/mirror ports when DEBUG_REGFILE_EN is defined.
module rv32_core
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [XLEN-1:0]      i_inst,
  input  logic [XLEN-1:0]      i_mem,
`ifdef DEBUG_REGFILE_EN
  input  logic                 i_dload,
  input  logic [RIDX-1:0]      i_daddr,
  input  logic [XLEN-1:0]      i_ddata,
  output logic [NREG*XLEN-1:0] o_reg,
`endif
  output logic                 o_write,
  output logic                 o_load,
  output logic [XLEN-1:0]      o_pc,
  output logic [XLEN-1:0]      o_mem,
  output logic [XLEN-1:0]      o_addr,
  output logic [1:0]           o_memsize
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] regs [NREG];

  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [RIDX-1:0] rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] pc_plus4;

  logic [XLEN-1:0] alu_x, alu_y, alu_res;
  alu_op_e         alu_op;
  logic            alu_op2, alu_zero;

  logic            wb_en, taken;
  logic [XLEN-1:0] wb_data, next_pc;
  memsize_e        msz;

  assign opcode = i_inst[6:2];
  assign funct3 = i_inst[14:12];
  assign rd     = i_inst[11:7];
  assign rs1    = i_inst[19:15];
  assign rs2    = i_inst[24:20];

  assign rs1_val = (rs1 == '0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : regs[rs2];

  assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign imm_u = {i_inst[31:12], 12'b0};

  assign pc_plus4 = pc + XLEN'(4);

  rv32_alu u_alu (
    .x      (alu_x),
    .y      (alu_y),
    .op     (alu_op),
    .op2    (alu_op2),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Branch condition from the compare the ALU was set up to perform.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      BR_BEQ:           taken = alu_zero;
      BR_BNE:           taken = !alu_zero;
      BR_BLT, BR_BLTU:  taken = alu_res[0];
      BR_BGE, BR_BGEU:  taken = !alu_res[0];
      default:          taken = 1'b0;
    endcase
  end

  // Decode: operand/op selection, writeback source, next PC, memory controls.
  // Encodings with inst[1:0] != 2'b11 are outside RV32I and execute as NOP.
  always_comb begin
    alu_x   = rs1_val;
    alu_y   = imm_i;
    alu_op  = ALU_ADD;
    alu_op2 = 1'b0;
    wb_en   = 1'b0;
    wb_data = alu_res;
    next_pc = pc_plus4;
    o_load  = 1'b0;
    o_write = 1'b0;
    msz     = MSZ_NONE;
    if (i_inst[1:0] == 2'b11) begin
      case (opcode)
        OPC_LUI: begin
          alu_x = '0;
          alu_y = imm_u;
          wb_en = 1'b1;
        end
        OPC_AUIPC: begin
          alu_x = pc;
          alu_y = imm_u;
          wb_en = 1'b1;
        end
        OPC_JAL: begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          next_pc = pc + imm_j;
        end
        OPC_JALR: begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          next_pc = {alu_res[XLEN-1:1], 1'b0};
        end
        OPC_BRANCH: begin
          alu_y = rs2_val;
          case (funct3[2:1])
            2'b10:   alu_op = ALU_SLT;
            2'b11:   alu_op = ALU_SLTU;
            default: alu_op2 = 1'b1;
          endcase
          if (taken) next_pc = pc + imm_b;
        end
        OPC_LOAD: begin
          o_load  = 1'b1;
          wb_en   = 1'b1;
          wb_data = load_extend(funct3, i_mem);
        end
        OPC_STORE: begin
          alu_y   = imm_s;
          o_write = 1'b1;
          case (funct3)
            ST_SB:   msz = MSZ_BYTE;
            ST_SH:   msz = MSZ_HALF;
            ST_SW:   msz = MSZ_WORD;
            default: msz = MSZ_NONE;
          endcase
        end
        OPC_OPIMM: begin
          alu_op  = alu_op_e'(funct3);
          alu_op2 = (alu_op_e'(funct3) == ALU_SRL) && i_inst[30];
          wb_en   = 1'b1;
        end
        OPC_OP: begin
          alu_y   = rs2_val;
          alu_op  = alu_op_e'(funct3);
          alu_op2 = i_inst[30];
          wb_en   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // PC and register file; debug load overrides the instruction's write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc <= RESET_PC;
      for (int unsigned k = 0; k < NREG; k++) regs[k] <= '0;
    end else begin
      pc <= next_pc;
      if (wb_en && (rd != '0)) regs[rd] <= wb_data;
`ifdef DEBUG_REGFILE_EN
      if (i_dload && (i_daddr != '0)) regs[i_daddr] <= i_ddata;
`endif
    end
  end

`ifdef DEBUG_REGFILE_EN
  for (genvar k = 0; k < NREG; k++) begin : g_reg_mirror
    assign o_reg[k*XLEN +: XLEN] = regs[k];
  end
`endif

  assign o_pc      = pc;
  assign o_mem     = rs2_val;
  assign o_addr    = alu_res;
  assign o_memsize = msz;

endmodule

// File: tb/tb_rv32_core.sv
// Scoreboarded bench for rv32_core: instructions are generated as abstract
// records, encoded to RV32I bits, and executed on an architectural model.
module tb_rv32_core;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef enum int {
    K_LUI, K_AUIPC, K_JAL, K_JALR,
    K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
    K_LB, K_LH, K_LW, K_LBU, K_LHU,
    K_SB, K_SH, K_SW,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_ILL
  } kind_e;

  typedef struct {
    kind_e       k;
    int          rd;
    int          rs1;
    int          rs2;
    logic [31:0] imm;
  } instr_t;

  typedef struct {
    logic [31:0] pc;
    logic        wr;
    logic        ld;
    logic [1:0]  msz;
    logic        addr_v;
    logic [31:0] addr;
    logic [31:0] mem;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] mem_in;
  logic        dbg_load;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        o_write, o_load;
  logic [31:0] o_pc, o_mem, o_addr;
  logic [1:0]  o_memsize;
`ifdef DEBUG_REGFILE_EN
  logic [1023:0] o_reg;
`endif

  always #5 clk = ~clk;

  rv32_core #(.RESET_PC(RST_PC)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_inst    (inst),
    .i_mem     (mem_in),
`ifdef DEBUG_REGFILE_EN
    .i_dload   (dbg_load),
    .i_daddr   (dbg_addr),
    .i_ddata   (dbg_data),
    .o_reg     (o_reg),
`endif
    .o_write   (o_write),
    .o_load    (o_load),
    .o_pc      (o_pc),
    .o_mem     (o_mem),
    .o_addr    (o_addr),
    .o_memsize (o_memsize)
  );

  int   total  = 0;
  int   passed = 0;
  exp_t expq[$];

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
  endtask

  function automatic instr_t mk(kind_e k, int rd, int rs1, int rs2, logic [31:0] imm);
    instr_t t;
    t.k = k; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  function automatic logic [2:0] f3_of(kind_e k);
    case (k)
      K_BNE, K_LH, K_SH, K_SLLI, K_SLL:                 return 3'd1;
      K_LW, K_SW, K_SLTI, K_SLT:                        return 3'd2;
      K_SLTIU, K_SLTU:                                  return 3'd3;
      K_BLT, K_LBU, K_XORI, K_XOR:                      return 3'd4;
      K_BGE, K_LHU, K_SRLI, K_SRAI, K_SRL, K_SRA:       return 3'd5;
      K_BLTU, K_ORI, K_OR:                              return 3'd6;
      K_BGEU, K_ANDI, K_AND:                            return 3'd7;
      default:                                          return 3'd0;
    endcase
  endfunction

  // Standard RV32I instruction formats.
  function automatic logic [31:0] enc(instr_t t);
    logic [4:0]  d, a, b;
    logic [2:0]  f;
    logic [31:0] m;
    d = 5'(t.rd); a = 5'(t.rs1); b = 5'(t.rs2); f = f3_of(t.k); m = t.imm;
    case (t.k)
      K_LUI:   return {m[31:12], d, 7'b0110111};
      K_AUIPC: return {m[31:12], d, 7'b0010111};
      K_JAL:   return {m[20], m[10:1], m[11], m[19:12], d, 7'b1101111};
      K_JALR:  return {m[11:0], a, 3'b000, d, 7'b1100111};
      K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU:
               return {m[12], m[10:5], b, a, f, m[4:1], m[11], 7'b1100011};
      K_LB, K_LH, K_LW, K_LBU, K_LHU:
               return {m[11:0], a, f, d, 7'b0000011};
      K_SB, K_SH, K_SW:
               return {m[11:5], b, a, f, m[4:0], 7'b0100011};
      K_SLLI, K_SRLI: return {7'b0000000, m[4:0], a, f, d, 7'b0010011};
      K_SRAI:  return {7'b0100000, m[4:0], a, f, d, 7'b0010011};
      K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI:
               return {m[11:0], a, f, d, 7'b0010011};
      K_SUB, K_SRA: return {7'b0100000, b, a, f, d, 7'b0110011};
      K_ADD, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_OR, K_AND:
               return {7'b0000000, b, a, f, d, 7'b0110011};
      default: return {m[24:0], (a[0] ? 7'b1110011 : 7'b0001111)};
    endcase
  endfunction

  // Architectural reference: one instruction's visible outputs and state update.
  task automatic model_exec(input instr_t t, input logic [31:0] mem, output exp_t e);
    logic [31:0] a, b, npc, wv, ea;
    logic        wr;
    a = m_regs[t.rs1]; b = m_regs[t.rs2];
    npc = m_pc + 32'd4; wr = 1'b1; wv = '0; ea = a + t.imm;
    e.pc = m_pc; e.wr = 1'b0; e.ld = 1'b0; e.msz = 2'd0;
    e.addr_v = 1'b0; e.addr = ea; e.mem = b;
    case (t.k)
      K_LUI:   wv = t.imm;
      K_AUIPC: wv = m_pc + t.imm;
      K_JAL:   begin wv = m_pc + 32'd4; npc = m_pc + t.imm; end
      K_JALR:  begin wv = m_pc + 32'd4; npc = ea & ~32'd1; end
      K_BEQ:   begin wr = 1'b0; if (a == b) npc = m_pc + t.imm; end
      K_BNE:   begin wr = 1'b0; if (a != b) npc = m_pc + t.imm; end
      K_BLT:   begin wr = 1'b0; if ($signed(a) <  $signed(b)) npc = m_pc + t.imm; end
      K_BGE:   begin wr = 1'b0; if ($signed(a) >= $signed(b)) npc = m_pc + t.imm; end
      K_BLTU:  begin wr = 1'b0; if (a <  b) npc = m_pc + t.imm; end
      K_BGEU:  begin wr = 1'b0; if (a >= b) npc = m_pc + t.imm; end
      K_LB:    begin e.ld = 1'b1; e.addr_v = 1'b1; wv = 32'($signed(mem[7:0])); end
      K_LH:    begin e.ld = 1'b1; e.addr_v = 1'b1; wv = 32'($signed(mem[15:0])); end
      K_LW:    begin e.ld = 1'b1; e.addr_v = 1'b1; wv = mem; end
      K_LBU:   begin e.ld = 1'b1; e.addr_v = 1'b1; wv = 32'(mem[7:0]); end
      K_LHU:   begin e.ld = 1'b1; e.addr_v = 1'b1; wv = 32'(mem[15:0]); end
      K_SB:    begin wr = 1'b0; e.wr = 1'b1; e.addr_v = 1'b1; e.msz = 2'd1; end
      K_SH:    begin wr = 1'b0; e.wr = 1'b1; e.addr_v = 1'b1; e.msz = 2'd2; end
      K_SW:    begin wr = 1'b0; e.wr = 1'b1; e.addr_v = 1'b1; e.msz = 2'd3; end
      K_ADDI:  wv = a + t.imm;
      K_SLTI:  wv = 32'($signed(a) < $signed(t.imm));
      K_SLTIU: wv = 32'(a < t.imm);
      K_XORI:  wv = a ^ t.imm;
      K_ORI:   wv = a | t.imm;
      K_ANDI:  wv = a & t.imm;
      K_SLLI:  wv = a << t.imm[4:0];
      K_SRLI:  wv = a >> t.imm[4:0];
      K_SRAI:  wv = 32'($signed(a) >>> t.imm[4:0]);
      K_ADD:   wv = a + b;
      K_SUB:   wv = a - b;
      K_SLL:   wv = a << b[4:0];
      K_SLT:   wv = 32'($signed(a) < $signed(b));
      K_SLTU:  wv = 32'(a < b);
      K_XOR:   wv = a ^ b;
      K_SRL:   wv = a >> b[4:0];
      K_SRA:   wv = 32'($signed(a) >>> b[4:0]);
      K_OR:    wv = a | b;
      K_AND:   wv = a & b;
      default: wr = 1'b0;
    endcase
    if (wr && t.rd != 0) m_regs[t.rd] = wv;
    if (dbg_load && dbg_addr != 5'd0) m_regs[dbg_addr] = dbg_data;
    m_pc = npc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = RST_PC;
  endtask

  // Drive one instruction for one cycle; called at 1ns after a rising edge.
  task automatic issue(input instr_t t, input logic [31:0] mem);
    exp_t e;
    inst = enc(t); mem_in = mem;
    model_exec(t, mem, e);
    expq.push_back(e);
    @(posedge clk); #1;
  endtask

  // Expose a register on o_mem with SW xk,0(x0) and also compare to a fixed value.
  task automatic peek_reg(input int k, input logic [31:0] v, input string nm);
    exp_t e;
    instr_t t;
    t = mk(K_SW, 0, 0, k, 32'd0);
    inst = enc(t); mem_in = '0;
    model_exec(t, '0, e);
    expq.push_back(e);
    #1 chk(nm, o_mem, v);
    @(posedge clk); #1;
  endtask

  function automatic int rreg();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
  endfunction

  function automatic instr_t rnd_instr();
    instr_t      t;
    logic [31:0] r;
    r = $urandom;
    t.k = kind_e'($urandom_range(0, int'(K_ILL)));
    t.rd = rreg(); t.rs1 = rreg(); t.rs2 = ($urandom_range(0, 3) == 0) ? t.rs1 : rreg();
    case (t.k)
      K_LUI, K_AUIPC: t.imm = {r[31:12], 12'h0};
      K_JAL:          t.imm = {{11{r[20]}}, r[20:1], 1'b0};
      K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU:
                      t.imm = {{19{r[12]}}, r[12:1], 1'b0};
      K_SLLI, K_SRLI, K_SRAI: t.imm = {27'b0, r[4:0]};
      default:        t.imm = {{20{r[11]}}, r[11:0]};
    endcase
    return t;
  endfunction

  // Monitor: every cycle with an outstanding expectation is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("pc", o_pc, e.pc);
        chk("write", 32'(o_write), 32'(e.wr));
        chk("load", 32'(o_load), 32'(e.ld));
        chk("memsize", 32'(o_memsize), 32'(e.msz));
        if (e.addr_v) chk("addr", o_addr, e.addr);
        if (e.wr) chk("store_data", o_mem, e.mem);
      end
    end
  end

  initial begin
    rst = 1'b1; inst = 32'h0000_0013; mem_in = '0;
    dbg_load = 1'b0; dbg_addr = '0; dbg_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("reset_pc", o_pc, RST_PC);
    rst = 1'b0;

    issue(mk(K_ADDI, 1, 0, 0, 32'd5), 0);
    issue(mk(K_ADDI, 2, 0, 0, 32'hFFFF_FFFD), 0);
    issue(mk(K_ADD, 3, 1, 2, 0), 0);
    chk("pc_after_add", o_pc, 32'd12);
    peek_reg(3, 32'd2, "add_x3");
    issue(mk(K_AUIPC, 6, 0, 0, 32'h0000_1000), 0);
    issue(mk(K_LUI, 5, 0, 0, 32'h1234_5000), 0);
    issue(mk(K_SUB, 4, 1, 2, 0), 0);
    issue(mk(K_SLT, 7, 2, 1, 0), 0);
    issue(mk(K_SLTU, 8, 2, 1, 0), 0);
    issue(mk(K_ADDI, 9, 0, 0, 32'hFFFF_FFF0), 0);
    issue(mk(K_SRAI, 9, 9, 0, 32'd2), 0);
    issue(mk(K_LUI, 10, 0, 0, 32'h8000_0000), 0);
    issue(mk(K_SRLI, 10, 10, 0, 32'd31), 0);
    issue(mk(K_ADDI, 0, 0, 0, 32'd7), 0);
    peek_reg(4, 32'd8, "sub_x4");
    peek_reg(5, 32'h1234_5000, "lui_x5");
    peek_reg(6, 32'h0000_1010, "auipc_x6");
    peek_reg(7, 32'd1, "slt_x7");
    peek_reg(8, 32'd0, "sltu_x8");
    peek_reg(9, 32'hFFFF_FFFC, "srai_x9");
    peek_reg(10, 32'd1, "srli_x10");
    peek_reg(0, 32'd0, "x0_zero");
    issue(mk(K_ADDI, 11, 0, 0, 32'h100), 0);
    issue(mk(K_SW, 0, 11, 2, 32'd8), 0);
    issue(mk(K_LB, 12, 0, 0, 0), 32'h0000_0080);
    issue(mk(K_LBU, 13, 0, 0, 0), 32'h0000_0080);
    peek_reg(12, 32'hFFFF_FF80, "lb_x12");
    peek_reg(13, 32'h0000_0080, "lbu_x13");

    issue(mk(K_JALR, 0, 0, 0, 32'h20), 0);
    chk("jalr_to_20", o_pc, 32'h20);
    issue(mk(K_BEQ, 0, 1, 1, 32'd16), 0);
    chk("beq_taken", o_pc, 32'h30);
    issue(mk(K_BNE, 0, 1, 1, 32'd8), 0);
    chk("bne_not_taken", o_pc, 32'h34);
    issue(mk(K_JALR, 0, 0, 0, 32'h40), 0);
    issue(mk(K_JAL, 1, 0, 0, 32'hFFFF_FFF8), 0);
    chk("jal_target", o_pc, 32'h38);
    peek_reg(1, 32'h44, "jal_link");
    issue(mk(K_ADDI, 1, 0, 0, 32'h101), 0);
    issue(mk(K_JALR, 1, 1, 0, 32'd3), 0);
    chk("jalr_target", o_pc, 32'h104);
    peek_reg(1, 32'h44, "jalr_link");
    issue(mk(K_ADDI, 14, 0, 0, 32'd1), 0);
    issue(mk(K_ADDI, 15, 0, 0, 32'hFFFF_FFFF), 0);
    issue(mk(K_BLTU, 0, 14, 15, 32'd8), 0);
    chk("bltu_taken", o_pc, 32'h118);

    for (int n = 0; n < 600; n++) issue(rnd_instr(), $urandom);

    // Reset in the middle of an instruction: it must not commit.
    inst = enc(mk(K_ADDI, 1, 0, 0, 32'd99));
    #2 rst = 1'b1;
    #1 chk("midrun_reset_pc", o_pc, RST_PC);
    for (int k = 1; k < 32; k++) begin
      inst = enc(mk(K_SW, 0, 0, k, 0));
      #1 chk($sformatf("reset_x%0d", k), o_mem, 32'd0);
    end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    chk("pc_after_release", o_pc, RST_PC);

    for (int n = 0; n < 200; n++) issue(rnd_instr(), $urandom);

`ifdef DEBUG_REGFILE_EN
    dbg_load = 1'b1; dbg_addr = 5'd7; dbg_data = 32'h0000_DEAD;
    issue(mk(K_ADDI, 7, 0, 0, 32'd1), 0);
    dbg_load = 1'b0;
    chk("dbg_oreg7", o_reg[7*32 +: 32], 32'h0000_DEAD);
    peek_reg(7, 32'h0000_DEAD, "dbg_x7");
    dbg_load = 1'b1; dbg_addr = 5'd0; dbg_data = 32'h1234_5678;
    issue(mk(K_ADDI, 0, 0, 0, 32'd0), 0);
    dbg_load = 1'b0;
    chk("dbg_x0_ignored", o_reg[31:0], 32'd0);
`endif

    for (int i = 0; i < 4 && expq.size() != 0; i++) @(negedge clk);
    if (expq.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
